// File: rtl/sha256_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_controller
// Description : Sequencing controller for the SHA-256 compression datapath.
//               It accepts one 512-bit block per start handshake, then steps
//               the datapath through working-register load, 64 rounds,
//               hash-state update and completion.
//               It owns the round counter, which addresses the K ROM and the
//               W selectors. The first MSG_WORDS rounds stall until a
//               message word is available. It contains no hash arithmetic.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, first_block  - block request and IV-select (sampled
//                                     when start is accepted)
//               msg_valid           - message word present for this round
//               ready, busy         - idle / in-flight status
//               iv_load, work_load  - INIT strobes
//               round_en, round     - round execute strobe and round index
//               w_sel, msg_ready    - W source select, message request
//               h_update, done      - hash-state update, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_round_controller #(
    parameter int ROUNDS    = 64,
    parameter int MSG_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       first_block,
    input  logic       msg_valid,
    output logic       ready,
    output logic       busy,
    output logic       iv_load,
    output logic       work_load,
    output logic       round_en,
    output logic [5:0] round,
    output logic       w_sel,
    output logic       msg_ready,
    output logic       h_update,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);
    localparam logic [5:0] c_msg_words  = 6'(MSG_WORDS);

    state_t     r_state;
    logic [5:0] r_round;
    logic       r_first_q;

    logic       w_in_round;
    logic       w_msg_phase;
    logic       w_round_en;

    // During the message phase a round only advances when its word is
    // present; msg_valid is qualified combinationally so a word offered in
    // the same cycle as msg_ready is consumed immediately.
    always_comb begin
        w_in_round  = (r_state == S_ROUND);
        w_msg_phase = w_in_round && (r_round < c_msg_words);
        w_round_en  = w_in_round && (w_msg_phase ? msg_valid : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_round   <= 6'd0;
            r_first_q <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_first_q <= first_block;
                        r_state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_round <= 6'd0;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_round_en) begin
                        if (r_round == c_last_round) begin
                            r_round <= 6'd0;
                            r_state <= S_FINAL;
                        end else begin
                            r_round <= r_round + 6'd1;
                        end
                    end
                end
                S_FINAL: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: begin
                    r_state <= S_IDLE;
                    r_round <= 6'd0;
                end
            endcase
        end
    end

    // All strobes are a pure decode of the registered state; only round_en
    // additionally depends on msg_valid during the message phase.
    always_comb begin
        ready     = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        iv_load   = (r_state == S_INIT) && r_first_q;
        work_load = (r_state == S_INIT);
        round_en  = w_round_en;
        round     = w_in_round ? r_round : 6'd0;
        w_sel     = w_msg_phase;
        msg_ready = w_msg_phase;
        h_update  = (r_state == S_FINAL);
        done      = (r_state == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_round_controller
// Description : Self-checking bench for sha256_round_controller. A
//               block-position model predicts every output each cycle, and
//               a small SHA-256 datapath driven by the controller strobes
//               must produce the "abc" reference digest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_round_controller;

    logic       clk = 1'b0;
    logic       rst, start, first_block, msg_valid;
    logic       ready, busy, iv_load, work_load, round_en, w_sel, msg_ready, h_update, done;
    logic [5:0] round;

    sha256_round_controller #(.ROUNDS(64), .MSG_WORDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .first_block(first_block),
        .msg_valid(msg_valid), .ready(ready), .busy(busy), .iv_load(iv_load),
        .work_load(work_load), .round_en(round_en), .round(round), .w_sel(w_sel),
        .msg_ready(msg_ready), .h_update(h_update), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a block is a sequence of 67 steps after acceptance
    // (pos 0 = load, 1..64 = rounds 0..63, 65 = hash update, 66 = done);
    // message-phase rounds do not advance without msg_valid.
    // ------------------------------------------------------------------
    logic m_busy = 1'b0;
    logic m_first = 1'b0;
    int   m_pos = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_pos   <= 0;
            m_first <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_pos   <= 0;
                m_first <= first_block;
            end
        end else if (m_pos >= 1 && m_pos <= 16 && !msg_valid) begin
            m_pos <= m_pos;
        end else if (m_pos == 66) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            automatic logic       e_in   = m_busy && m_pos >= 1 && m_pos <= 64;
            automatic logic       e_msg  = e_in && m_pos <= 16;
            automatic logic [5:0] e_rnd  = e_in ? 6'(m_pos - 1) : 6'd0;
            automatic logic [14:0] exp_v = {!m_busy, m_busy,
                                            m_busy && m_pos == 0 && m_first,
                                            m_busy && m_pos == 0,
                                            e_in && (!e_msg || msg_valid),
                                            e_rnd, e_msg, e_msg,
                                            m_busy && m_pos == 65,
                                            m_busy && m_pos == 66};
            chk("outputs{rdy,busy,iv,wl,ren,round,wsel,mrdy,hup,done}",
                {ready, busy, iv_load, work_load, round_en, round, w_sel,
                 msg_ready, h_update, done}, exp_v);
        end
    end

    // ------------------------------------------------------------------
    // Event monitor: pulse counts and latencies relative to the accept edge.
    // ------------------------------------------------------------------
    int e = 0;
    always @(posedge clk) e <= e + 1;

    int acc_cnt = 0, done_cnt = 0, h_cnt = 0, iv_cnt = 0, wl_cnt = 0, ws_cnt = 0, ren_cnt = 0;
    int t_acc = 0, done_lat = 0, h_lat = 0, iv_lat = 0;
    int acc_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (ready && start) begin
                acc_cnt <= acc_cnt + 1;
                t_acc   <= e + 1;
                acc_q.push_back(e + 1);
            end
            if (done)      begin done_cnt <= done_cnt + 1; done_lat <= e + 1 - t_acc; end
            if (h_update)  begin h_cnt    <= h_cnt + 1;    h_lat    <= e + 1 - t_acc; end
            if (iv_load)   begin iv_cnt   <= iv_cnt + 1;   iv_lat   <= e + 1 - t_acc; end
            if (work_load) wl_cnt  <= wl_cnt + 1;
            if (w_sel)     ws_cnt  <= ws_cnt + 1;
            if (round_en)  ren_cnt <= ren_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference SHA-256 datapath driven only by the controller strobes.
    // ------------------------------------------------------------------
    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] c_iv =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_abc_digest =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, f, g, h, ee, t1, t2;
        {a, b, c, d, ee, f, g, h} = s;
        t1 = h + (rotr(ee, 6) ^ rotr(ee, 11) ^ rotr(ee, 25)) + ((ee & f) ^ (~ee & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, ee, f, g};
    endfunction

    function automatic logic [255:0] hadd(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    logic [31:0]  msg  [16];
    logic [31:0]  wsch [64];
    logic [255:0] hh, wk;
    logic [31:0]  wt;

    always_comb begin
        automatic logic [5:0]  r   = round;
        automatic logic [31:0] w2  = wsch[r - 6'd2];
        automatic logic [31:0] w15 = wsch[r - 6'd15];
        wt = 32'd0;
        if (w_sel) wt = msg[r[3:0]];
        else wt = (rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10)) + wsch[r - 6'd7]
                + (rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3)) + wsch[r - 6'd16];
    end

    always @(posedge clk) begin
        if (work_load) wk <= iv_load ? c_iv : hh;
        if (iv_load)   hh <= c_iv;
        if (round_en) begin
            wk          <= rnd(wk, c_k[round], wt);
            wsch[round] <= wt;
        end
        if (h_update)  hh <= hadd(hh, wk);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic start_block(input logic f);
        int prev = acc_cnt;
        first_block = f;
        start       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != prev) break;
        end
        chk("accept_seen", 256'(acc_cnt != prev), 256'd1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != prev) break;
            @(posedge clk); #1;
        end
        chk("done_seen", 256'(done_cnt != prev), 256'd1);
    endtask

    int b_done, b_iv, b_wl, b_ws, b_ren, b_acc, b_h;

    task automatic snap();
        b_done = done_cnt; b_iv = iv_cnt; b_wl = wl_cnt; b_ws = ws_cnt;
        b_ren = ren_cnt; b_acc = acc_cnt; b_h = h_cnt;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        rst = 1'b1; start = 1'b0; first_block = 1'b0; msg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_ready", 256'(ready), 256'd1);
        chk("reset_busy",  256'(busy),  256'd0);
        chk("reset_round", 256'(round), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // first_block=1, no stalls
        msg_valid = 1'b1;
        snap();
        start_block(1'b1);
        wait_done(b_done);
        chk("a_iv_lat",   256'(iv_lat),   256'd1);
        chk("a_iv_cnt",   256'(iv_cnt - b_iv), 256'd1);
        chk("a_h_lat",    256'(h_lat),    256'd66);
        chk("a_done_lat", 256'(done_lat), 256'd67);
        chk("a_wsel_cnt", 256'(ws_cnt - b_ws),   256'd16);
        chk("a_ren_cnt",  256'(ren_cnt - b_ren), 256'd64);
        chk("a_digest",   hh, c_abc_digest);

        // first_block=0 chains from H: no IV load, same timing
        @(posedge clk); #1;
        snap();
        start_block(1'b0);
        wait_done(b_done);
        chk("b_iv_cnt",   256'(iv_cnt - b_iv), 256'd0);
        chk("b_wl_cnt",   256'(wl_cnt - b_wl), 256'd1);
        chk("b_done_lat", 256'(done_lat), 256'd67);

        // stalls: 3 cycles at round 5 (cycles 7..9), 2 at round 15 (20..21),
        // msg_valid toggles after the message phase
        @(posedge clk); #1;
        snap();
        start_block(1'b1);
        for (int k = 1; k < 72; k++) begin
            if (k == 7 || k == 8 || k == 9 || k == 20 || k == 21) msg_valid = 1'b0;
            else if (k >= 23) msg_valid = k[0];
            else msg_valid = 1'b1;
            @(posedge clk); #1;
        end
        msg_valid = 1'b1;
        wait_done(b_done);
        chk("s_done_lat", 256'(done_lat), 256'd72);
        chk("s_ren_cnt",  256'(ren_cnt - b_ren), 256'd64);
        chk("s_digest",   hh, c_abc_digest);

        // start held for three blocks
        @(posedge clk); #1;
        snap();
        first_block = 1'b1;
        start       = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (acc_cnt >= b_acc + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("held_acc_cnt", 256'(acc_cnt - b_acc), 256'd3);
        wait_done(b_done + 2);
        if (acc_q.size() >= b_acc + 3) begin
            chk("held_gap1", 256'(acc_q[b_acc + 1] - acc_q[b_acc]),     256'd68);
            chk("held_gap2", 256'(acc_q[b_acc + 2] - acc_q[b_acc + 1]), 256'd68);
        end else begin
            chk("held_acc_q", 256'(acc_q.size()), 256'(b_acc + 3));
        end
        chk("held_done_cnt", 256'(done_cnt - b_done), 256'd3);

        // reset at round 30 aborts the block; start during reset is ignored
        @(posedge clk); #1;
        start_block(1'b1);
        for (int i = 0; i < 100; i++) begin
            if (round == 6'd30) break;
            @(posedge clk); #1;
        end
        chk("abort_round30", 256'(round), 256'd30);
        snap();
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_ready", 256'(ready), 256'd1);
        chk("abort_round", 256'(round), 256'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("abort_no_hup",  256'(h_cnt - b_h),       256'd0);
        chk("abort_no_done", 256'(done_cnt - b_done), 256'd0);
        chk("abort_no_acc",  256'(acc_cnt - b_acc),   256'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
